// File: rtl/apb_uart_pkg.sv
// Shared APB UART constants: TX state encoding and frame bit indices.
// TX_PARITY_EN moves the stop-bit index up by one to make room for parity.
package apb_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_PAR   = 3'd4,
    ST_STOP  = 3'd5
  } tx_state_e;

  // These mirror the RX upper-count values so both sides agree on frame shape.
  localparam int LAST_BIT_M0 = 8;
  localparam int LAST_BIT_M1 = 10;
`ifdef TX_PARITY_EN
  localparam int STOP_BIT_M0 = 10;
  localparam int STOP_BIT_M1 = 12;
`else
  localparam int STOP_BIT_M0 = 9;
  localparam int STOP_BIT_M1 = 11;
`endif

  function automatic int last_bit(input logic m);
    return m ? LAST_BIT_M1 : LAST_BIT_M0;
  endfunction

  function automatic int stop_bit(input logic m);
    return m ? STOP_BIT_M1 : STOP_BIT_M0;
  endfunction

endpackage

// File: rtl/apb_tx_cp_if.sv
// Word handshake between the APB register side and the UART TX control path.
interface apb_tx_cp_if #(
  parameter int DATA_W = 10
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/apb_tx_shift.sv
// TX load/shift register; the frame's even parity is captured at load time.
// Parity output exists only when TX_PARITY_EN is defined.
module apb_tx_shift #(
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic              clr,
  input  logic              mode,
  input  logic [DATA_W-1:0] data,
  output logic              lsb,
  output logic              lsb_nxt
`ifdef TX_PARITY_EN
  ,
  output logic              parity
`endif
);

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] word;

  // Mode 0 frames carry only the low byte; upper bits are forced to zero.
  assign word = mode ? data : {{(DATA_W-8){1'b0}}, data[7:0]};

  always_comb begin
    shift_d = shift_q;
    if (clr)        shift_d = '0;
    else if (load)  shift_d = word;
    else if (shift) shift_d = shift_q >> 1;
  end

  always_ff @(posedge clk) begin
    if (rst) shift_q <= '0;
    else     shift_q <= shift_d;
  end

  assign lsb     = shift_q[0];
  assign lsb_nxt = shift_q[1];

`ifdef TX_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (clr)       par_d = 1'b0;
    else if (load) par_d = ^word;
  end

  always_ff @(posedge clk) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_d;
  end

  assign parity = par_q;
`endif

endmodule

// File: rtl/apb_tx_cp.sv
// UART transmit control path: start, LSB-first data, stop; one bit per baud tick.
// Define TX_PARITY_EN to insert an even-parity bit before stop.
module apb_tx_cp
  import apb_uart_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic             tx_en,
  input  logic             mode,
  input  logic             baud_clk,
  apb_tx_cp_if.slave       tx_if,
  output logic             txd,
  output logic             tx_busy,
  output logic             tx_done,
  output logic [CNT_W-1:0] bit_cnt
);

  tx_state_e        state_q, state_d;
  logic             txd_q, txd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

  logic tx_ready, abort;
  logic sh_load, sh_shift, sh_clr, sh_lsb, sh_lsb_nxt;
`ifdef TX_PARITY_EN
  logic sh_par;
`endif

  assign tx_ready       = (state_q == ST_IDLE) && !rst && sel && tx_en;
  assign tx_if.tx_ready = tx_ready;
  assign abort          = (state_q != ST_IDLE) && !(sel && tx_en);

  apb_tx_shift #(.DATA_W(DATA_W)) u_shift (
    .clk     (clk),
    .rst     (rst),
    .load    (sh_load),
    .shift   (sh_shift),
    .clr     (sh_clr),
    .mode    (mode),
    .data    (tx_if.tx_data),
    .lsb     (sh_lsb),
    .lsb_nxt (sh_lsb_nxt)
`ifdef TX_PARITY_EN
    ,
    .parity  (sh_par)
`endif
  );

  always_comb begin
    state_d   = state_q;
    txd_d     = txd_q;
    done_d    = 1'b0;
    mode_d    = mode_q;
    bit_cnt_d = bit_cnt_q;
    sh_load   = 1'b0;
    sh_shift  = 1'b0;
    sh_clr    = 1'b0;
    // Abort outranks any coincident baud tick and discards the word.
    if (abort) begin
      state_d   = ST_IDLE;
      txd_d     = 1'b1;
      bit_cnt_d = '0;
      sh_clr    = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: if (tx_if.tx_valid && tx_ready) begin
          sh_load   = 1'b1;
          mode_d    = mode;
          state_d   = ST_ARM;
          txd_d     = 1'b1;
          bit_cnt_d = '0;
        end
        // Waiting one tick aligns the start bit to a full baud period.
        ST_ARM: if (baud_clk) begin
          state_d   = ST_START;
          txd_d     = 1'b0;
          bit_cnt_d = '0;
        end
        ST_START: if (baud_clk) begin
          state_d   = ST_DATA;
          txd_d     = sh_lsb;
          bit_cnt_d = CNT_W'(1);
        end
        ST_DATA: if (baud_clk) begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(last_bit(mode_q))) begin
`ifdef TX_PARITY_EN
            state_d = ST_PAR;
            txd_d   = sh_par;
`else
            state_d = ST_STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            sh_shift = 1'b1;
            txd_d    = sh_lsb_nxt;
          end
        end
`ifdef TX_PARITY_EN
        ST_PAR: if (baud_clk) begin
          state_d   = ST_STOP;
          txd_d     = 1'b1;
          bit_cnt_d = CNT_W'(stop_bit(mode_q));
        end
`endif
        ST_STOP: if (baud_clk) begin
          state_d   = ST_IDLE;
          txd_d     = 1'b1;
          done_d    = 1'b1;
          bit_cnt_d = '0;
        end
        default: begin
          state_d   = ST_IDLE;
          txd_d     = 1'b1;
          bit_cnt_d = '0;
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mode_q    <= 1'b0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      mode_q    <= mode_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign txd     = txd_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;
  assign bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_apb_tx_cp.sv
// Directed + randomized bench for apb_tx_cp; frames are modelled as bit lists.
module tb_apb_tx_cp;

  logic       clk = 1'b0;
  logic       rst, sel, tx_en, mode, baud_clk;
  logic       txd, tx_busy, tx_done;
  logic [3:0] bit_cnt;
  int         n_chk = 0;
  int         n_err = 0;
  int         done_cnt = 0;
  bit         exp_q[$];

  apb_tx_cp_if #(.DATA_W(10)) tx_if ();

  apb_tx_cp #(.DATA_W(10), .CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .tx_en    (tx_en),
    .mode     (mode),
    .baud_clk (baud_clk),
    .tx_if    (tx_if),
    .txd      (txd),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .bit_cnt  (bit_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (tx_done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    baud_clk = 1'b1;
    step();
    baud_clk = 1'b0;
  endtask

  // Line levels after each tick: start, data LSB-first, [even parity], stop.
  task automatic build(input logic [9:0] d, input bit m);
    bit p;
    p = 1'b0;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < (m ? 10 : 8); i++) begin
      exp_q.push_back(d[i]);
      p ^= d[i];
    end
`ifdef TX_PARITY_EN
    exp_q.push_back(p);
`endif
    exp_q.push_back(1'b1);
  endtask

  // ab_kind: 0 drop tx_en, 1 drop sel, 2 pulse rst; applied after tick ab_at.
  task automatic send(input logic [9:0] d, input bit m, input int gap, input bit pre,
                      input bit hold, input logic [9:0] nd, input int ab_at, input int ab_kind);
    int w, d0;
    if (!pre) begin
      tx_if.tx_data  = d;
      mode           = m;
      tx_if.tx_valid = 1'b1;
      w = 0;
      while (tx_if.tx_ready !== 1'b1 && w < 40) begin
        step();
        w++;
      end
      chk("ready_wait", 32'(tx_if.tx_ready), 1);
      step();
    end
    d0 = done_cnt;
    chk("arm_busy", 32'(tx_busy), 1);
    chk("arm_txd", 32'(txd), 1);
    chk("arm_ready", 32'(tx_if.tx_ready), 0);
    if (hold) tx_if.tx_data = nd;
    else      tx_if.tx_valid = 1'b0;
    mode = ~m;
    build(d, m);
    for (int k = 0; k < exp_q.size(); k++) begin
      tick();
      chk("txd", 32'(txd), 32'(exp_q[k]));
      chk("bit_cnt", 32'(bit_cnt), k);
      chk("busy", 32'(tx_busy), 1);
      chk("no_done", 32'(tx_done), 0);
      if (k == ab_at) begin
        baud_clk = 1'b1;
        case (ab_kind)
          0:       tx_en = 1'b0;
          1:       sel   = 1'b0;
          default: rst   = 1'b1;
        endcase
        step();
        baud_clk = 1'b0;
        chk("ab_txd", 32'(txd), 1);
        chk("ab_cnt", 32'(bit_cnt), 0);
        chk("ab_busy", 32'(tx_busy), 0);
        chk("ab_done", 32'(tx_done), 0);
        chk("ab_ready", 32'(tx_if.tx_ready), 0);
        rst = 1'b0;
        sel = 1'b1;
        tx_en = 1'b1;
        step();
        chk("ab_ready_back", 32'(tx_if.tx_ready), 1);
        chk("ab_done_cnt", done_cnt, d0);
        return;
      end
      repeat (gap - 1) step();
    end
    if (hold) mode = m;
    tick();
    chk("done", 32'(tx_done), 1);
    chk("end_cnt", 32'(bit_cnt), 0);
    chk("end_txd", 32'(txd), 1);
    chk("end_busy", 32'(tx_busy), 0);
    chk("end_ready", 32'(tx_if.tx_ready), 1);
    step();
    chk("done_pulse", 32'(tx_done), 0);
    chk("done_cnt", done_cnt, d0 + 1);
  endtask

  initial begin
    rst = 1'b1; sel = 1'b1; tx_en = 1'b1; mode = 1'b0; baud_clk = 1'b0;
    tx_if.tx_data = '0; tx_if.tx_valid = 1'b0;
    step();
    step();
    chk("rst_txd", 32'(txd), 1);
    chk("rst_busy", 32'(tx_busy), 0);
    chk("rst_done", 32'(tx_done), 0);
    chk("rst_cnt", 32'(bit_cnt), 0);
    chk("rst_ready", 32'(tx_if.tx_ready), 0);
    rst = 1'b0;
    step();
    chk("idle_ready", 32'(tx_if.tx_ready), 1);

    tick();
    chk("idle_tick_txd", 32'(txd), 1);
    chk("idle_tick_busy", 32'(tx_busy), 0);

    sel = 1'b0;
    tx_if.tx_valid = 1'b1;
    step();
    chk("nosel_ready", 32'(tx_if.tx_ready), 0);
    chk("nosel_busy", 32'(tx_busy), 0);
    tx_if.tx_valid = 1'b0;
    sel = 1'b1;
    step();

    send(10'h0A5, 1'b0, 16, 1'b0, 1'b0, 10'h0, -1, 0);
    send(10'h2A5, 1'b1, 16, 1'b0, 1'b0, 10'h0, -1, 0);
    send(10'h0A4, 1'b0, 16, 1'b0, 1'b0, 10'h0, -1, 0);

    send(10'h0FF, 1'b0, 8, 1'b0, 1'b1, 10'h000, -1, 0);
    send(10'h000, 1'b0, 8, 1'b1, 1'b0, 10'h0, -1, 0);

    send(10'($urandom), 1'b0, 6, 1'b0, 1'b0, 10'h0, 4, 0);
    send(10'($urandom), 1'b1, 5, 1'b0, 1'b0, 10'h0, 7, 1);
    send(10'($urandom), 1'b0, 5, 1'b0, 1'b0, 10'h0, 0, 2);

    for (int r = 0; r < 8; r++)
      send(10'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(1, 12)),
           1'b0, 1'b0, 10'h0, -1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
